// File: rtl/blk_seq.sv
// Cipher-core sequencer: key load, then a batch of blocks with a scope trigger ahead of each core_drdy.
// Latency: core_drdy TRIG_DLY+1 cycles after cmd_run; the core paces via core_kvld/core_dvld, bounded by TIMEOUT.
module blk_seq #(
    parameter int TIMEOUT  = 1024,
    parameter int TRIG_DLY = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_key,
    input  logic         cmd_run,
    input  logic         cmd_abort,
    input  logic         err_clr,
    input  logic         chain,
    input  logic [15:0]  run_count,
    input  logic [127:0] kin,
    input  logic [127:0] din,
    input  logic         encdec,
    output logic [127:0] core_kin,
    output logic [127:0] core_din,
    output logic         core_encdec,
    output logic         core_krdy,
    output logic         core_drdy,
    output logic         core_rstn,
    input  logic         core_kvld,
    input  logic         core_dvld,
    input  logic [127:0] core_dout,
    output logic [127:0] dout,
    output logic         done,
    output logic         busy,
    output logic         trig,
    output logic         key_ok,
    output logic         err_nokey,
    output logic         err_tmo
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int TW = $clog2(TRIG_DLY + 1);

    typedef enum logic [2:0] {IDLE, KREQ, KWAIT, TRIG, DREQ, DWAIT} state_t;

    state_t        state;
    logic [15:0]   remaining;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] trig_cnt;
    logic          wait_tmo;

    // A valid arriving on the last allowed cycle suppresses the timeout.
    assign wait_tmo = (((state == KWAIT) && !core_kvld) || ((state == DWAIT) && !core_dvld))
                      && (wait_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            core_kin    <= '0;
            core_din    <= '0;
            core_encdec <= 1'b0;
            core_krdy   <= 1'b0;
            core_drdy   <= 1'b0;
            core_rstn   <= 1'b1;
            dout        <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            trig        <= 1'b0;
            key_ok      <= 1'b0;
            err_nokey   <= 1'b0;
            err_tmo     <= 1'b0;
            remaining   <= '0;
            wait_cnt    <= '0;
            trig_cnt    <= '0;
        end else begin
            core_krdy <= 1'b0;
            core_drdy <= 1'b0;
            core_rstn <= 1'b1;
            done      <= 1'b0;
            // Error sets further down override this clear in the same cycle.
            if (err_clr) begin
                err_nokey <= 1'b0;
                err_tmo   <= 1'b0;
            end

            if ((state != IDLE) && cmd_abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                trig      <= 1'b0;
                core_rstn <= 1'b0;
                key_ok    <= 1'b0;
            end else if (wait_tmo) begin
                state     <= IDLE;
                busy      <= 1'b0;
                core_rstn <= 1'b0;
                key_ok    <= 1'b0;
                err_tmo   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_key) begin
                            core_kin  <= kin;
                            core_krdy <= 1'b1;
                            busy      <= 1'b1;
                            state     <= KREQ;
                        end else if (cmd_run) begin
                            if (key_ok) begin
                                core_din    <= din;
                                core_encdec <= encdec;
                                remaining   <= (run_count == 16'd0) ? 16'd1 : run_count;
                                trig        <= 1'b1;
                                trig_cnt    <= TW'(1);
                                busy        <= 1'b1;
                                state       <= TRIG;
                            end else begin
                                err_nokey <= 1'b1;
                            end
                        end
                    end
                    KREQ: begin
                        wait_cnt <= '0;
                        state    <= KWAIT;
                    end
                    KWAIT: begin
                        if (core_kvld) begin
                            key_ok <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end
                    TRIG: begin
                        if (trig_cnt == TW'(TRIG_DLY)) begin
                            trig      <= 1'b0;
                            core_drdy <= 1'b1;
                            state     <= DREQ;
                        end else begin
                            trig_cnt <= trig_cnt + TW'(1);
                        end
                    end
                    DREQ: begin
                        wait_cnt <= '0;
                        state    <= DWAIT;
                    end
                    DWAIT: begin
                        if (core_dvld) begin
                            dout <= core_dout;
                            if (remaining != 16'd0) begin
                                remaining <= remaining - 16'd1;
                            end
                            if (remaining <= 16'd1) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                if (chain) begin
                                    core_din <= core_dout;
                                end
                                trig     <= 1'b1;
                                trig_cnt <= TW'(1);
                                state    <= TRIG;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        trig  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_blk_seq.sv
// Directed bench for blk_seq: a fake core answers with core_dout = core_din + 1, and a block-level
// scoreboard predicts every core_din at core_drdy, the final dout, pulse counts and error flags.
module tb_blk_seq;
    localparam int TIMEOUT  = 1024;
    localparam int TRIG_DLY = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_key, cmd_run, cmd_abort, err_clr, chain, encdec;
    logic [15:0]  run_count;
    logic [127:0] kin, din;
    logic [127:0] core_kin, core_din, core_dout, dout;
    logic         core_encdec, core_krdy, core_drdy, core_rstn, core_kvld, core_dvld;
    logic         done, busy, trig, key_ok, err_nokey, err_tmo;

    always #5 clk = ~clk;

    blk_seq #(.TIMEOUT(TIMEOUT), .TRIG_DLY(TRIG_DLY)) dut (
        .clk(clk), .rst(rst), .cmd_key(cmd_key), .cmd_run(cmd_run), .cmd_abort(cmd_abort),
        .err_clr(err_clr), .chain(chain), .run_count(run_count), .kin(kin), .din(din),
        .encdec(encdec), .core_kin(core_kin), .core_din(core_din), .core_encdec(core_encdec),
        .core_krdy(core_krdy), .core_drdy(core_drdy), .core_rstn(core_rstn),
        .core_kvld(core_kvld), .core_dvld(core_dvld), .core_dout(core_dout), .dout(dout),
        .done(done), .busy(busy), .trig(trig), .key_ok(key_ok), .err_nokey(err_nokey),
        .err_tmo(err_tmo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_krdy = 0, n_drdy = 0, n_done = 0, n_rstn = 0;
    int drdy_cyc = 0, rstn_cyc = 0, trun = 0;
    int k_delay = 10, d_delay = 5;
    logic withhold = 1'b0;

    logic [127:0] exp_key  = '0;
    logic [127:0] exp_dout = '0;
    logic         exp_enc  = 1'b0;
    logic [127:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] fcore(input logic [127:0] x);
        return x + 128'd1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while ((busy !== 1'b0) && (n < limit)) begin
            tick();
            n++;
        end
        chkb("idle_within_bound", busy, 1'b0);
    endtask

    // Fake cipher core: answers core_krdy after k_delay cycles and core_drdy after d_delay cycles.
    initial begin
        int kcnt;
        int dcnt;
        logic [127:0] blk_in;
        kcnt = 0;
        dcnt = 0;
        blk_in = '0;
        core_kvld = 1'b0;
        core_dvld = 1'b0;
        core_dout = '0;
        forever begin
            tick();
            core_kvld = 1'b0;
            core_dvld = 1'b0;
            if (kcnt > 0) begin
                kcnt--;
                if (kcnt == 0) core_kvld = 1'b1;
            end
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    core_dvld = 1'b1;
                    core_dout = fcore(blk_in);
                end
            end
            if (core_krdy) kcnt = k_delay;
            if (core_drdy && !withhold) begin
                dcnt   = d_delay;
                blk_in = core_din;
            end
        end
    end

    // Per-cycle comparison against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("core_kin_stable", core_kin, exp_key);
            if (core_krdy) n_krdy++;
            if (core_drdy) begin
                n_drdy++;
                drdy_cyc = cyc;
                chki("drdy_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("core_din_at_drdy", core_din, exp_q.pop_front());
                chkb("core_encdec_at_drdy", core_encdec, exp_enc);
            end
            if (done) begin
                n_done++;
                chk("dout_at_done", dout, exp_dout);
            end
            if (!core_rstn) begin
                n_rstn++;
                rstn_cyc = cyc;
            end
            if (trig) begin
                trun++;
            end else begin
                if (trun > 0) begin
                    if (core_drdy) chki("trig_len", trun, TRIG_DLY);
                    else chkb("trig_cut_by_abort", core_rstn, 1'b0);
                end
                trun = 0;
            end
        end
    end

    task automatic load_key(input logic [127:0] k, input logic run_too);
        int n, k0, d0;
        k0 = n_krdy;
        d0 = n_drdy;
        kin = k;
        cmd_key = 1'b1;
        cmd_run = run_too;
        tick();
        cmd_key = 1'b0;
        cmd_run = 1'b0;
        exp_key = k;
        wait_idle(200, n);
        chki("key_cycles_to_idle", n, 11);
        chkb("key_ok_after_load", key_ok, 1'b1);
        chkb("no_err_nokey_after_load", err_nokey, 1'b0);
        tick();
        chki("krdy_pulses", n_krdy - k0, 1);
        chki("no_drdy_during_key", n_drdy - d0, 0);
    endtask

    task automatic run_batch(input logic [127:0] d, input logic [15:0] cnt, input logic ch,
                             input logic enc, input logic [127:0] lit_dout);
        int n, nb, d0, n0, r0;
        logic [127:0] x, y;
        nb = (cnt == 16'd0) ? 1 : int'(cnt);
        x = d;
        y = d;
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(x);
            y = fcore(x);
            x = ch ? y : d;
        end
        exp_dout = y;
        exp_enc = enc;
        d0 = n_drdy;
        n0 = n_done;
        r0 = n_rstn;
        din = d;
        run_count = cnt;
        chain = ch;
        encdec = enc;
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chkb("busy_after_run", busy, 1'b1);
        wait_idle(3000, n);
        tick();
        chki("drdy_pulses", n_drdy - d0, nb);
        chki("done_pulses", n_done - n0, 1);
        chki("no_core_reset", n_rstn - r0, 0);
        chk("dout_final", dout, lit_dout);
        chki("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n, d0, n0, r0;
        rst = 1'b1;
        cmd_key = 1'b0; cmd_run = 1'b0; cmd_abort = 1'b0; err_clr = 1'b0;
        chain = 1'b0; encdec = 1'b0; run_count = 16'd0; kin = '0; din = '0;
        tick();
        tick();
        chkb("rst_core_rstn", core_rstn, 1'b1);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_key_ok", key_ok, 1'b0);
        chkb("rst_err_nokey", err_nokey, 1'b0);
        chkb("rst_err_tmo", err_tmo, 1'b0);
        chkb("rst_trig", trig, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_krdy", core_krdy, 1'b0);
        chkb("rst_drdy", core_drdy, 1'b0);
        chk("rst_dout", dout, '0);
        chk("rst_core_din", core_din, '0);
        chk("rst_core_kin", core_kin, '0);
        rst = 1'b0;
        tick();

        load_key(128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C, 1'b0);

        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chkb("idle_abort_rstn", core_rstn, 1'b1);
        chkb("idle_abort_key_ok", key_ok, 1'b1);
        chkb("idle_abort_busy", busy, 1'b0);

        run_batch(128'h3243F6A8_885A308D_313198A2_E0370734, 16'd1, 1'b0, 1'b0,
                  128'h3243F6A8_885A308D_313198A2_E0370735);
        run_batch(128'h10, 16'd3, 1'b1, 1'b1, 128'h13);
        run_batch(128'h20, 16'd2, 1'b0, 1'b0, 128'h21);
        run_batch(128'h40, 16'd0, 1'b1, 1'b1, 128'h41);

        d0 = n_drdy;
        r0 = n_rstn;
        din = 128'h77;
        run_count = 16'd5;
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chkb("in_trig", trig, 1'b1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chkb("abort_rstn_low", core_rstn, 1'b0);
        chkb("abort_busy", busy, 1'b0);
        chkb("abort_key_ok", key_ok, 1'b0);
        chkb("abort_no_err_nokey", err_nokey, 1'b0);
        chkb("abort_no_err_tmo", err_tmo, 1'b0);
        tick();
        chkb("abort_rstn_back", core_rstn, 1'b1);
        chki("abort_rstn_cycles", n_rstn - r0, 1);
        chki("abort_no_drdy", n_drdy - d0, 0);

        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chkb("nokey_err", err_nokey, 1'b1);
        chkb("nokey_busy", busy, 1'b0);
        tick();
        chkb("nokey_busy_later", busy, 1'b0);
        chki("nokey_no_drdy", n_drdy - d0, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chkb("err_clr_nokey", err_nokey, 1'b0);
        err_clr = 1'b1;
        cmd_run = 1'b1;
        tick();
        err_clr = 1'b0;
        cmd_run = 1'b0;
        chkb("err_set_beats_clr", err_nokey, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chkb("err_clr_again", err_nokey, 1'b0);

        load_key(128'h000102030405060708090A0B0C0D0E0F, 1'b1);

        d_delay = TIMEOUT;
        run_batch(128'h99, 16'd1, 1'b0, 1'b0, 128'h9A);
        chkb("late_valid_no_tmo", err_tmo, 1'b0);
        d_delay = 5;

        withhold = 1'b1;
        d0 = n_drdy;
        n0 = n_done;
        r0 = n_rstn;
        exp_q.push_back(128'h55);
        exp_enc = 1'b0;
        din = 128'h55;
        run_count = 16'd1;
        chain = 1'b0;
        encdec = 1'b0;
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        wait_idle(TIMEOUT + 100, n);
        chkb("tmo_rstn_low", core_rstn, 1'b0);
        chkb("tmo_err", err_tmo, 1'b1);
        chkb("tmo_key_ok", key_ok, 1'b0);
        tick();
        chkb("tmo_rstn_back", core_rstn, 1'b1);
        chki("tmo_rstn_cycles", n_rstn - r0, 1);
        chki("tmo_delay_from_drdy", rstn_cyc - drdy_cyc, TIMEOUT + 1);
        chki("tmo_no_done", n_done - n0, 0);
        chki("tmo_one_drdy", n_drdy - d0, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chkb("err_clr_tmo", err_tmo, 1'b0);

        load_key(128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C, 1'b0);
        n0 = n_done;
        r0 = n_rstn;
        exp_q.push_back(128'h66);
        din = 128'h66;
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        exp_key = '0;
        rst = 1'b0;
        chkb("midrst_busy", busy, 1'b0);
        chkb("midrst_rstn", core_rstn, 1'b1);
        chkb("midrst_key_ok", key_ok, 1'b0);
        chk("midrst_dout", dout, '0);
        chk("midrst_core_din", core_din, '0);
        tick();
        tick();
        chki("midrst_no_done", n_done - n0, 0);
        chki("midrst_no_core_reset", n_rstn - r0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end
endmodule

// File: doc/blk_seq.md
BLK_SEQ -- requirements
Module: blk_seq

Interface
REQ-001 Parameter TIMEOUT, default 1024, gives the max cycles waited for core_kvld/core_dvld.
REQ-002 Parameter TRIG_DLY, default 3, gives the cycles trig is held before core_drdy.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be (name  dir  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_key  in  1  pulse: load key
- cmd_run  in  1  pulse: start batch
- cmd_abort  in  1  pulse: abort current operation
- err_clr  in  1  pulse: clear sticky errors
- chain  in  1  1 = next block input is the previous output
- run_count  in  16  blocks per batch
- kin  in  128  key
- din  in  128  first data block
- encdec  in  1  0 = encrypt, 1 = decrypt
- core_kin  out  128  key to the cipher core
- core_din  out  128  data to the cipher core
- core_encdec  out  1  direction to the cipher core
- core_krdy  out  1  key-ready pulse
- core_drdy  out  1  data-ready pulse
- core_rstn  out  1  core reset, active-low
- core_kvld  in  1  key expansion done
- core_dvld  in  1  block done
- core_dout  in  128  core result
- dout  out  128  last captured result
- done  out  1  batch-complete pulse
- busy  out  1  state is not IDLE
- trig  out  1  scope trigger
- key_ok  out  1  key loaded
- err_nokey  out  1  sticky error: run issued without a key
- err_tmo  out  1  sticky error: core timeout

Function
REQ-005 The FSM SHALL have states IDLE, KREQ, KWAIT, TRIG, DREQ, DWAIT.
REQ-006 In IDLE with cmd_key=1: latch kin to core_kin, go to KREQ; this has priority over a simultaneous cmd_run, which is dropped.
REQ-007 In IDLE with cmd_run=1 and key_ok=1:
- latch din to core_din and encdec to core_encdec;
- load remaining with run_count, or with 1 when run_count=0;
- go to TRIG.
REQ-008 In IDLE with cmd_run=1 and key_ok=0: set err_nokey and stay in IDLE.
REQ-009 KREQ SHALL assert core_krdy for exactly one cycle, then go to KWAIT.
REQ-010 KWAIT: on core_kvld, set key_ok=1 and go to IDLE.
REQ-011 TRIG SHALL hold trig=1 for TRIG_DLY consecutive cycles, then go to DREQ.
REQ-012 DREQ SHALL assert core_drdy for exactly one cycle, then go to DWAIT.
REQ-013 DWAIT on core_dvld:
- capture core_dout into dout;
- decrement remaining;
- if remaining was 1: pulse done one cycle and go to IDLE;
- otherwise go to TRIG, loading core_din with core_dout if chain=1, or keeping it if chain=0.
REQ-014 The wait counter SHALL clear on entering KWAIT or DWAIT.
REQ-015 If the wait counter reaches TIMEOUT with no valid:
- drive core_rstn=0 for one cycle;
- set err_tmo and clear key_ok;
- go to IDLE with no done pulse.
REQ-016 cmd_abort in any non-IDLE state SHALL:
- drive core_rstn=0 for one cycle;
- clear key_ok;
- go to IDLE with no done pulse and no error set.
REQ-017 cmd_abort in IDLE SHALL be ignored.
REQ-018 cmd_key and cmd_run SHALL be ignored outside IDLE.
REQ-019 core_kvld/core_dvld SHALL be ignored outside KWAIT/DWAIT.
REQ-020 A valid and a timeout in the same cycle: the valid wins.
REQ-021 A valid and cmd_abort in the same cycle: the abort wins.
REQ-022 err_clr SHALL clear both sticky errors; an error set in the same cycle SHALL win.
REQ-023 core_kin, core_din and core_encdec SHALL stay stable from latch until the next latch.
REQ-024 remaining SHALL be 16-bit unsigned and SHALL never wrap below 0.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On rst:
- state = IDLE;
- core_rstn = 1;
- all other outputs, core_kin, core_din, dout, remaining, the counters and errors = 0.
REQ-027 rst mid-batch SHALL abandon the batch without a done pulse and without driving core_rstn low.

Verification
REQ-028 Key load: cmd_key with kin=0x2B7E1516_28AED2A6_ABF71588_09CF4F3C, core_kvld 10 cycles after core_krdy -> one core_krdy pulse; key_ok=1 and busy=0 the next cycle.
REQ-029 Single block: run_count=1, chain=0 -> trig high 3 cycles, then one core_drdy; on core_dvld, dout=core_dout and done pulses once.
REQ-030 Chained batch: run_count=3, chain=1 -> 3 core_drdy pulses; core_din of blocks 2 and 3 = the previous core_dout; exactly one done pulse.
REQ-031 No key: cmd_run with key_ok=0 -> err_nokey=1 and busy stays 0; err_clr -> err_nokey=0.
REQ-032 Timeout: withhold core_dvld -> after 1024 cycles, one core_rstn=0 cycle, err_tmo=1, key_ok=0, no done pulse.
REQ-033 Abort and corners: cmd_abort in TRIG -> IDLE with one core_rstn=0 cycle; cmd_key+cmd_run in the same IDLE cycle -> only the key load runs; run_count=0 -> exactly 1 block.
